// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte sink among NREQ requesters; zero-latency data path.
// Optional macro UART_TX_ARB_PRIORITY_EN makes requester 0 urgent at arbitration time (no preemption).
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [7:0]      burst_cnt_q;
    logic [15:0]     idle_cnt_q;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;

    logic [7:0]      burst_cnt_d;
    logic [15:0]     idle_cnt_d;
    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic            ptr_upd;
    logic            owner_vld;
    logic            owner_last;
    logic [7:0]      owner_dat;
    logic            xfer;
    logic            burst_hit;
    logic            timeout_hit;

    // Search starts just after the last owner, so it has lowest priority next time.
    always_comb begin
        int cand;
        logic [PW-1:0] cand_idx;
        win_vld  = 1'b0;
        win_idx  = '0;
        ptr_upd  = 1'b1;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = PW'(cand);
            if (!win_vld && req_valid[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
`ifdef UART_TX_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
            ptr_upd = 1'b0;
        end
`endif
    end

    assign owner_vld  = req_valid[owner_q];
    assign owner_last = req_last[owner_q];
    assign owner_dat  = req_data[8*owner_q +: 8];

    assign tx_valid = (state_q == SEND) && owner_vld;
    assign tx_data  = (state_q == SEND) ? owner_dat : 8'h00;

    always_comb begin
        req_ready = '0;
        if (state_q == SEND) req_ready[owner_q] = tx_ready;
    end

    assign xfer        = tx_valid & tx_ready;
    assign burst_cnt_d = burst_cnt_q + 8'd1;
    assign idle_cnt_d  = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 16'd1;
    assign burst_hit   = (burst_cnt_d == 8'(MAX_BURST));
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt_q == 16'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= PW'(NREQ - 1);
            burst_cnt_q <= 8'd0;
            idle_cnt_q  <= 16'd0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q     <= SEND;
                        owner_q     <= win_idx;
                        burst_cnt_q <= 8'd0;
                        idle_cnt_q  <= 16'd0;
                        grant_q     <= NREQ'(1) << win_idx;
                        busy_q      <= 1'b1;
                        if (ptr_upd) rr_ptr_q <= win_idx;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        burst_cnt_q <= burst_cnt_d;
                        idle_cnt_q  <= 16'd0;
                        if (owner_last || burst_hit) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (!owner_vld) begin
                        // Sink backpressure with valid high never counts as an owner stall.
                        if (timeout_hit) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            idle_cnt_q <= idle_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, cycle-level reference model, directed and random phases.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int MAXB = 16;
    localparam int TO   = 8;
    localparam int DEPTH = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester sources: bit 8 = last flag, bits 7:0 = byte.
    logic [8:0]      src_mem [NREQ][DEPTH];
    int              rd_p [NREQ];
    int              wr_p [NREQ];
    logic [NREQ-1:0] hold;

    // Reference model: owner (-1 = nobody), last owner, bytes this grant, stalled cycles.
    int m_own = -1;
    int m_ptr = NREQ - 1;
    int m_cnt = 0;
    int m_idle = 0;
    int cyc = 0;
    int gnt_log[$];
    int gnt_cyc[$];
    int tx_log[$];

    task automatic load(input int r, input int n, input int base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            src_mem[r][wr_p[r]] = {(with_last && k == n - 1), 8'((base + k) & 255)};
            wr_p[r]++;
        end
    endtask

    task automatic flush_all();
        for (int r = 0; r < NREQ; r++) begin
            rd_p[r] = 0;
            wr_p[r] = 0;
        end
        gnt_log.delete();
        gnt_cyc.delete();
        tx_log.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rd_p[i] < wr_p[i]) begin
                req_valid[i]       = !hold[i];
                req_data[8*i +: 8] = src_mem[i][rd_p[i]][7:0];
                req_last[i]        = src_mem[i][rd_p[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] hs;
        int w;
        bit urgent;
        bit xf;
        drive();
        @(negedge clk);
        if (m_own >= 0) begin
            check("grant", grant_o, 1 << m_own);
            check("busy", busy_o, 1);
            check("tx_valid", tx_valid, req_valid[m_own]);
            check("tx_data", tx_data, req_data[8*m_own +: 8]);
            check("req_ready", req_ready, tx_ready ? (1 << m_own) : 0);
        end else begin
            check("grant", grant_o, 0);
            check("busy", busy_o, 0);
            check("tx_valid", tx_valid, 0);
            check("tx_data", tx_data, 0);
            check("req_ready", req_ready, 0);
        end
        hs = req_valid & req_ready;
        xf = (m_own >= 0) && req_valid[m_own] && tx_ready;
        if (xf) tx_log.push_back((m_own << 9) | (int'(req_last[m_own]) << 8) | int'(req_data[8*m_own +: 8]));
        if (reset) begin
            m_own = -1; m_ptr = NREQ - 1; m_cnt = 0; m_idle = 0;
        end else if (m_own < 0) begin
            w = -1;
            urgent = 1'b0;
`ifdef UART_TX_ARB_PRIORITY_EN
            if (req_valid[0]) begin w = 0; urgent = 1'b1; end
`endif
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
                m_own = w; m_cnt = 0; m_idle = 0;
                if (!urgent) m_ptr = w;
                gnt_log.push_back(w);
                gnt_cyc.push_back(cyc);
            end
        end else if (xf) begin
            m_cnt++;
            m_idle = 0;
            if (req_last[m_own] || m_cnt == MAXB) m_own = -1;
        end else if (!req_valid[m_own]) begin
            if (TO != 0 && m_idle == TO - 1) m_own = -1;
            else if (m_idle < 65535) m_idle++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (hs[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        hold = '0;
        tx_ready = 1'b1;
        flush_all();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int first1;
        reset = 1'b1;
        hold = '0;
        tx_ready = 1'b1;
        flush_all();
        drive();
        @(posedge clk);
        #1;
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);

        // Single 3-byte packet from requester 0.
        reset_dut();
        load(0, 3, 'h41, 1'b1);
        step();
        check("t1_grant_after_valid", grant_o, 4'b0001);
        step(); step(); step();
        check("t1_busy_fall", busy_o, 0);
        step();
        check("t1_idle_gap", grant_o, 0);
        check("t1_nbytes", tx_log.size(), 3);
        for (int k = 0; k < 3 && k < tx_log.size(); k++)
            check("t1_byte", tx_log[k], ('h41 + k) | ((k == 2) ? 'h100 : 0));

        // Everyone waiting with single-byte packets.
        reset_dut();
        for (int r = 0; r < NREQ; r++) begin
            load(r, 1, 'h10 * r, 1'b1);
            load(r, 1, 'h10 * r + 8, 1'b1);
        end
        for (int k = 0; k < 16; k++) step();
        check("t2_ngrants", gnt_log.size() >= 5, 1);
        if (gnt_log.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                check("t2_order", gnt_log[k], k % NREQ);
                if (k < 4) check("t2_spacing", gnt_cyc[k+1] - gnt_cyc[k], 2);
            end

        // Burst limit on an unterminated stream.
        reset_dut();
        load(2, 20, 0, 1'b0);
        step();
        load(1, 1, 'hA0, 1'b1);
        for (int k = 0; k < 200 && rd_p[2] < 20; k++) step();
        check("t3_drained", rd_p[2], 20);
        check("t3_ngrants", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check("t3_g0", gnt_log[0], 2);
            check("t3_g1", gnt_log[1], 1);
            check("t3_g2", gnt_log[2], 2);
        end
        first1 = -1;
        for (int k = 0; k < tx_log.size(); k++)
            if (first1 < 0 && (tx_log[k] >> 9) == 1) first1 = k;
        check("t3_burst_len", first1, MAXB);
        if (tx_log.size() > 17) check("t3_resume", tx_log[17], (2 << 9) | 16);

        // Owner stall timeout.
        reset_dut();
        load(1, 1, 'h55, 1'b0);
        step(); step();
        n = 0;
        while (busy_o && n < 50) begin step(); n++; end
        check("t4_timeout_cycles", n, TO);

        // Sink backpressure must not time out.
        reset_dut();
        load(1, 2, 'h60, 1'b1);
        tx_ready = 1'b0;
        step();
        for (int k = 0; k < 100; k++) step();
        check("t4_bp_busy", busy_o, 1);
        check("t4_bp_grant", grant_o, 4'b0010);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("t4_bp_drained", rd_p[1], 2);
        check("t4_bp_release", busy_o, 0);

        // Reset in the middle of a packet.
        reset_dut();
        load(0, 3, 'h70, 1'b1);
        step(); step();
        reset = 1'b1;
        step();
        check("t5_tx_valid", tx_valid, 0);
        check("t5_grant", grant_o, 0);
        reset = 1'b0;
        flush_all();
        for (int r = 0; r < NREQ; r++) load(r, 1, 'h80 + r, 1'b1);
        step();
        check("t5_next_grant", grant_o, 4'b0001);

`ifdef UART_TX_ARB_PRIORITY_EN
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            load(0, 1, k, 1'b1);
            load(3, 1, 'h30 + k, 1'b1);
        end
        for (int k = 0; k < 14; k++) step();
        check("t6_ngrants", gnt_log.size() >= 6, 1);
        if (gnt_log.size() >= 6) begin
            for (int k = 0; k < 5; k++) check("t6_urgent", gnt_log[k], 0);
            check("t6_then3", gnt_log[5], 3);
        end
`endif

        // Random traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (rd_p[r] == wr_p[r] && $urandom_range(0, 7) == 0)
                    load(r, $urandom_range(1, 20), $urandom_range(0, 255), $urandom_range(0, 3) != 0);
                hold[r] = ($urandom_range(0, 15) == 0);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
